// File: rtl/vproc_div_block.sv
// Iterative restoring radix-2 divider for one vector element lane.
// Returns quotient and remainder with RISC-V divide semantics, including divide-by-zero and signed overflow.
module vproc_div_block #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             async_rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             div_zero_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] quot_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             div_zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic             op2_zero;
    logic             sgn_ovf;

    // Dividend MSBs shift into the partial remainder; quotient bits fill the dividend from the LSB.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign q_bit     = ~trial[WIDTH];
    assign rem_d     = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign dvd_d     = {dvd_q[WIDTH-2:0], q_bit};

    assign op1_neg  = signed_i & op1_i[WIDTH-1];
    assign op2_neg  = signed_i & op2_i[WIDTH-1];
    assign op1_abs  = op1_neg ? (~op1_i + {{(WIDTH-1){1'b0}}, 1'b1}) : op1_i;
    assign op2_abs  = op2_neg ? (~op2_i + {{(WIDTH-1){1'b0}}, 1'b1}) : op2_i;
    assign op2_zero = (op2_i == {WIDTH{1'b0}});
    assign sgn_ovf  = signed_i & (op1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (op2_i == {WIDTH{1'b1}});

    // Divider control FSM and datapath registers.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            quot_out_q  <= {WIDTH{1'b0}};
            rem_out_q   <= {WIDTH{1'b0}};
            div_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        q_neg_q    <= 1'b0;
                        r_neg_q    <= 1'b0;
                        if (op2_zero) begin
                            dvd_q   <= {WIDTH{1'b1}};
                            rem_q   <= op1_i;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else if (sgn_ovf) begin
                            dvd_q   <= op1_i;
                            rem_q   <= {WIDTH{1'b0}};
                            dz_q    <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= op1_abs;
                            dvs_q   <= op2_abs;
                            rem_q   <= {WIDTH{1'b0}};
                            q_neg_q <= op1_neg ^ op2_neg;
                            r_neg_q <= op1_neg;
                            dz_q    <= 1'b0;
                            cnt_q   <= CW'(WIDTH - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (q_neg_q) begin
                        dvd_q <= ~dvd_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (r_neg_q) begin
                        rem_q <= ~rem_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; it is then held until taken.
                    if (!out_valid_q) begin
                        quot_out_q  <= dvd_q;
                        rem_out_q   <= rem_q;
                        div_zero_q  <= dz_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign quot_o      = quot_out_q;
    assign rem_o       = rem_out_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_vproc_div_block.sv
// Self-checking bench for vproc_div_block: directed plan cases plus randomized operations
// compared against an arithmetic reference model.
module tb_vproc_div_block;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         sgn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dz;

    int checks;
    int failures;

    vproc_div_block #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .async_rst_i (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .signed_i    (sgn),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quot_o      (quot),
        .rem_o       (rem),
        .div_zero_o  (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output int lat);
        int sa;
        int sb;
        z   = 1'b0;
        lat = W + 2;
        if (b == 16'h0000) begin
            q = 16'hFFFF; r = a; z = 1'b1; lat = 1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -32768 && sb == -1) begin
                q = a; r = 16'h0000; lat = 1;
            end else begin
                q = 16'(sa / sb);
                r = 16'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one operation, measure latency from the accept edge and compare the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           elat;
        int           n;
        ref_div(a, b, s, eq, er, ez, elat);
        @(negedge clk);
        check_eq("in_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op1 = a; op2 = b; sgn = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, elat);
        if (out_valid) begin
            check_eq("quot", {16'd0, quot}, {16'd0, eq});
            check_eq("rem", {16'd0, rem}, {16'd0, er});
            check_eq("div_zero", {31'd0, dz}, {31'd0, ez});
            check_eq("ready_in_done", {31'd0, in_ready}, 32'd0);
        end
    endtask

    // Hold the result for some cycles (with an ignored in_valid pulse), then take it.
    task automatic take_result(input int hold);
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        logic         hz;
        hq = quot; hr = rem; hz = dz;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 1); op1 = 16'h0055; op2 = 16'h0003; sgn = 1'b0;
            @(posedge clk);
            #1;
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("hold_quot", {16'd0, quot}, {16'd0, hq});
            check_eq("hold_rem", {16'd0, rem}, {16'd0, hr});
            check_eq("hold_dz", {31'd0, dz}, {31'd0, hz});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_take_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_take_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           sel;
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; sgn = 1'b0; out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_quot", {16'd0, quot}, 32'd0);
        check_eq("rst_rem", {16'd0, rem}, 32'd0);
        check_eq("rst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd100, 16'd7, 1'b0);        take_result(0);
        run_op(16'hFFF9, 16'h0002, 1'b1);    take_result(1);
        run_op(16'h0007, 16'hFFFE, 1'b1);    take_result(0);
        run_op(16'hFFFF, 16'h0001, 1'b0);    take_result(0);
        run_op(16'hFFFF, 16'h0001, 1'b1);    take_result(0);
        run_op(16'h1234, 16'h0000, 1'b0);    take_result(0);
        run_op(16'h1234, 16'h0000, 1'b1);    take_result(0);
        run_op(16'h8000, 16'hFFFF, 1'b1);    take_result(0);
        run_op(16'h8000, 16'hFFFF, 1'b0);    take_result(0);
        run_op(16'd77, 16'd9, 1'b0);         take_result(5);
        run_op(16'd50, 16'd5, 1'b0);         take_result(0);

        // Abort during the 8th CALC cycle.
        @(negedge clk);
        in_valid = 1'b1; op1 = 16'd999; op2 = 16'd7; sgn = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) check_eq("stray_result", {31'd0, out_valid}, 32'd0);
        end
        check_eq("idle_after_abort", {31'd0, in_ready}, 32'd1);
        run_op(16'd1000, 16'd33, 1'b0);      take_result(0);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            if (sel == 0) rb = 16'h0000;
            else if (sel == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
            else if (sel == 2) rb = 16'($urandom_range(1, 15));
            else if (sel == 3) rb = -16'($urandom_range(1, 15));
            run_op(ra, rb, rs);
            take_result($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
